// File: rtl/tpu_ctrl_pkg.sv
// Shared types and host address map for the TPU sequencing controller.
package tpu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RD_C_LO   = 2'd0,
      RD_C_HI   = 2'd1,
      RD_STATUS = 2'd2,
      RD_ZERO   = 2'd3
   } rdata_sel_t;

   localparam logic [15:0] A_BASE      = 16'h0100;
   localparam logic [15:0] A_LAST      = 16'h013F;
   localparam logic [15:0] B_BASE      = 16'h0200;
   localparam logic [15:0] B_LAST      = 16'h023F;
   localparam logic [15:0] C_BASE      = 16'h0300;
   localparam logic [15:0] C_LAST      = 16'h037F;
   localparam logic [15:0] START_ADDR  = 16'h0400;
   localparam logic [15:0] STATUS_ADDR = 16'h0408;

endpackage

// File: rtl/tpu_ctrl_decode.sv
// Combinational host address decode: range hits, legality and A/C row extraction.
module tpu_ctrl_decode
   import tpu_ctrl_pkg::*;
#(
   parameter int DIM     = 8,
   parameter int ADDRW   = 16,
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   localparam int RW     = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic [ADDRW-1:0] addr,
   input  logic             r_w,
   output logic             hit_a,
   output logic             hit_b,
   output logic             hit_c,
   output logic             hit_start,
   output logic             hit_status,
   output logic             illegal,
   output logic [RW-1:0]    a_row,
   output logic [RW-1:0]    c_row,
   output logic             c_half
);

   // Row stride in bytes is one full row of elements.
   localparam int ASH = $clog2(DIM * BITS_AB / 8);
   localparam int CSH = $clog2(DIM * BITS_C / 8);

   always_comb begin
      hit_a      = (addr >= ADDRW'(A_BASE)) && (addr <= ADDRW'(A_LAST));
      hit_b      = (addr >= ADDRW'(B_BASE)) && (addr <= ADDRW'(B_LAST));
      hit_c      = (addr >= ADDRW'(C_BASE)) && (addr <= ADDRW'(C_LAST));
      hit_start  = (addr == ADDRW'(START_ADDR));
      hit_status = (addr == ADDRW'(STATUS_ADDR));
      // START is write-only and STATUS read-only; the wrong direction is illegal.
      illegal    = !(hit_a || hit_b || hit_c || (hit_start && r_w) || (hit_status && !r_w));
      a_row      = '0;
      c_row      = '0;
      c_half     = 1'b0;
      if (hit_a) begin
         a_row = RW'((addr - ADDRW'(A_BASE)) >> ASH);
      end
      if (hit_c) begin
         c_row  = RW'((addr - ADDRW'(C_BASE)) >> CSH);
         c_half = addr[3];
      end
   end

endmodule

// File: rtl/tpu_ctrl.sv
// TPU sequencing controller: host decode, multiply FSM, sticky status flags.
// Optional completion interrupt enabled by defining TPU_CTRL_IRQ_EN.
module tpu_ctrl
   import tpu_ctrl_pkg::*;
#(
   parameter int DIM     = 8,
   parameter int ADDRW   = 16,
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   localparam int RW     = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             r_w,
   input  logic [ADDRW-1:0] addr,
   output logic             ready,
   output logic             a_wr,
   output logic [RW-1:0]    a_row,
   output logic             b_en,
   output logic             c_wr,
   output logic [RW-1:0]    c_row,
   output logic             c_half,
   output logic             sys_en,
   output logic [1:0]       rdata_sel,
   output logic [2:0]       status,
   output logic             irq
);

   localparam int CW   = (3 * DIM - 2 > 1) ? $clog2(3 * DIM - 2) : 1;
   localparam int LAST = 3 * DIM - 3;

   state_t      state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        hit_a, hit_b, hit_c, hit_start, hit_status, illegal;
   logic        rd_status, xfer;
   rdata_sel_t  rsel;

   tpu_ctrl_decode #(
      .DIM     (DIM),
      .ADDRW   (ADDRW),
      .BITS_AB (BITS_AB),
      .BITS_C  (BITS_C)
   ) u_decode (
      .addr       (addr),
      .r_w        (r_w),
      .hit_a      (hit_a),
      .hit_b      (hit_b),
      .hit_c      (hit_c),
      .hit_start  (hit_start),
      .hit_status (hit_status),
      .illegal    (illegal),
      .a_row      (a_row),
      .c_row      (c_row),
      .c_half     (c_half)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      done_d    = done_q;
      err_d     = err_q;
      sys_en    = 1'b0;
      rd_status = req && !r_w && hit_status;
      // Only STATUS polls get through while a multiply is in flight.
      ready     = (state_q == IDLE) || rd_status;
      xfer      = req && ready;

      case (state_q)
         IDLE: begin
            if (xfer && r_w && hit_start) begin
               count_d = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            sys_en  = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == CW'(LAST)) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (xfer && illegal) err_d = 1'b1;
      if (xfer && rd_status) begin
         err_d  = 1'b0;
         done_d = 1'b0;
      end
      if (state_q == DONE) done_d = 1'b1;

      a_wr = xfer && r_w && hit_a;
      b_en = xfer && r_w && hit_b;
      c_wr = xfer && r_w && hit_c;

      rsel = RD_C_LO;
      if (xfer && !r_w) begin
         if (hit_status)  rsel = RD_STATUS;
         else if (hit_c)  rsel = c_half ? RD_C_HI : RD_C_LO;
         else             rsel = RD_ZERO;
      end
      rdata_sel = rsel;

      status = {err_q, done_q, state_q != IDLE};
`ifdef TPU_CTRL_IRQ_EN
      irq = (state_q == DONE);
`else
      irq = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_tpu_ctrl.sv
// Self-checking bench for tpu_ctrl: directed plan steps plus random host traffic.
module tb_tpu_ctrl;

   localparam int DIM = 8;

   logic        clk = 1'b0;
   logic        rst_n, req, r_w;
   logic [15:0] addr;
   logic        ready, a_wr, b_en, c_wr, c_half, sys_en, irq;
   logic [2:0]  a_row, c_row, status;
   logic [1:0]  rdata_sel;

   int checks = 0;
   int errors = 0;
   int cyc, start_cyc, sysen_cnt;
   bit m_done, m_err;
   logic [15:0] bnd [10];

   tpu_ctrl #(.DIM(DIM), .ADDRW(16), .BITS_AB(8), .BITS_C(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr),
      .ready(ready), .a_wr(a_wr), .a_row(a_row), .b_en(b_en), .c_wr(c_wr),
      .c_row(c_row), .c_half(c_half), .sys_en(sys_en), .rdata_sel(rdata_sel),
      .status(status), .irq(irq)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0=A 1=B 2=C 3=START write 4=STATUS read 5=illegal
   function automatic int kind_of(input logic [15:0] a, input logic w);
      if (a >= 16'h0100 && a <= 16'h013F) return 0;
      if (a >= 16'h0200 && a <= 16'h023F) return 1;
      if (a >= 16'h0300 && a <= 16'h037F) return 2;
      if (a == 16'h0400 && w) return 3;
      if (a == 16'h0408 && !w) return 4;
      return 5;
   endfunction

   // One bus cycle: drive, check mid-cycle against the timing model, advance.
   task automatic op(input logic rq, input logic w, input logic [15:0] a);
      int k, ph;
      bit busy, sysx, dn, rdy, xf, half;
      req = rq; r_w = w; addr = a;
      #4;
      k    = kind_of(a, w);
      ph   = cyc - start_cyc;
      busy = (ph >= 1) && (ph <= 3 * DIM - 1);
      sysx = (ph >= 1) && (ph <= 3 * DIM - 2);
      dn   = (ph == 3 * DIM - 1);
      rdy  = !busy || (rq && k == 4);
      xf   = rq && rdy;
      half = (k == 2) && (((a - 16'h0300) % 16) >= 8);
      if (rq || !busy) chk("ready", ready, rdy);
      chk("sys_en", sys_en, sysx);
      chk("status", status, {m_err, m_done, busy});
      chk("a_wr", a_wr, xf && w && k == 0);
      chk("b_en", b_en, xf && w && k == 1);
      chk("c_wr", c_wr, xf && w && k == 2);
      if (xf && w && k == 0) chk("a_row", a_row, (a - 16'h0100) / 8);
      if (xf && w && k == 2) begin
         chk("c_row", c_row, (a - 16'h0300) / 16);
         chk("c_half", c_half, half);
      end
      if (xf && !w) chk("rdata_sel", rdata_sel, (k == 4) ? 2 : (k == 2) ? int'(half) : 3);
`ifdef TPU_CTRL_IRQ_EN
      chk("irq", irq, dn);
`else
      chk("irq", irq, 0);
`endif
      if (sys_en) sysen_cnt++;
      if (xf && k == 5) m_err = 1'b1;
      if (xf && k == 4) begin
         m_err  = 1'b0;
         m_done = 1'b0;
      end
      if (dn) m_done = 1'b1;
      if (xf && k == 3) start_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      bnd = '{16'h00FF, 16'h0140, 16'h01FF, 16'h0240, 16'h02FF,
              16'h0380, 16'h03FF, 16'h0401, 16'h0409, 16'h0500};
      rst_n = 1'b0; req = 1'b0; r_w = 1'b0; addr = '0;
      cyc = 0; start_cyc = -1000; m_done = 1'b0; m_err = 1'b0; sysen_cnt = 0;
      #2;
      chk("rst_ready", ready, 1);
      chk("rst_status", status, 0);
      chk("rst_sys_en", sys_en, 0);
      chk("rst_irq", irq, 0);
      chk("rst_strobes", {a_wr, b_en, c_wr}, 0);
      chk("rst_rdata_sel", rdata_sel, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Row/half decode writes and reads
      op(1, 1, 16'h0118);
      op(0, 0, 16'h0000);
      op(1, 1, 16'h0378);
      op(1, 0, 16'h0378);
      op(1, 1, 16'h0208);
      op(1, 0, 16'h0110);

      // Multiply with a C read stalled from T+5 until T+24
      sysen_cnt = 0;
      op(1, 1, 16'h0400);
      repeat (4) op(0, 0, 16'h0000);
      repeat (19) op(1, 0, 16'h0300);
      op(1, 0, 16'h0300);
      chk("sys_en_count", sysen_cnt, 3 * DIM - 2);
      op(1, 0, 16'h0408);
      op(1, 0, 16'h0408);

      // STATUS poll mid-run, then back-to-back START in first IDLE cycle
      op(1, 1, 16'h0400);
      repeat (4) op(0, 0, 16'h0000);
      op(1, 0, 16'h0408);
      repeat (18) op(0, 0, 16'h0000);
      op(1, 1, 16'h0400);
      repeat (24) op(0, 0, 16'h0000);
      op(1, 0, 16'h0408);

      // Illegal accesses set err
      op(1, 1, 16'h0500);
      op(1, 0, 16'h0400);
      op(1, 0, 16'h0408);
      op(1, 0, 16'h0408);

      // Asynchronous reset mid-run
      op(1, 1, 16'h0400);
      repeat (9) op(0, 0, 16'h0000);
      op(1, 1, 16'h0500);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sys_en", sys_en, 0);
      chk("arst_status", status, 0);
      chk("arst_ready", ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc = 0; start_cyc = -1000; m_done = 1'b0; m_err = 1'b0;

      // Random host traffic
      repeat (400) begin
         logic        rq, w;
         logic [15:0] a;
         rq = ($urandom_range(0, 3) != 0);
         w  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: a = 16'h0100 + 16'($urandom_range(0, 63));
            1: a = 16'h0200 + 16'($urandom_range(0, 63));
            2: a = 16'h0300 + 16'($urandom_range(0, 127));
            3: a = 16'h0400;
            4: a = bnd[$urandom_range(0, 9)];
            5: a = 16'($urandom);
            default: a = 16'h0408;
         endcase
         op(rq, w, a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tpu_ctrl.md
# tpu_ctrl

Sequencing controller between the host memory-mapped bus and the TPU datapath (A buffer, B FIFO, systolic array). Decodes host accesses into single-cycle write strobes and row indices. Runs a multiply for exactly 3*DIM-2 array-enable cycles and stalls the host while busy. Exposes a status word for polling and optional completion interrupt.

## Interface
- DIM, 8, array dimension; rows of A and C
- ADDRW, 16, host address width
- BITS_AB, 8, A/B element width; one A row = DIM*BITS_AB bits = one 64-bit word at defaults
- BITS_C, 16, C element width; one C row = two 64-bit words at defaults
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  host access request; holds addr/r_w stable until accepted
- r_w  in  1  1 = write, 0 = read
- addr  in  ADDRW  byte address
- ready  out  1  access accepted this cycle when req && ready
- a_wr  out  1  write-enable of A row a_row
- a_row  out  clog2(DIM)  A row index
- b_en  out  1  push dataIn into B
- c_wr  out  1  write-enable of C row c_row, half c_half
- c_row  out  clog2(DIM)  C row index
- c_half  out  1  0 = low 64 bits, 1 = high 64 bits
- sys_en  out  1  systolic array advance enable
- rdata_sel  out  2  read mux: 0 C low, 1 C high, 2 status, 3 zero
- status  out  3  {err, done, busy}
- irq  out  1  completion pulse

## Operation
- Address map: A 0x0100–0x013F, row = (addr-0x0100)>>3. B 0x0200–0x023F. C 0x0300–0x037F, row = (addr-0x0300)>>4, half = addr[3]. START write 0x0400. STATUS read 0x0408. Anything else is illegal.
- Transfer = req && ready. Strobes (a_wr, b_en, c_wr) are combinational and asserted only in the transfer cycle, and only for writes to their own range.
- Reads of A or B: accepted, rdata_sel = 3.
- Reads of C: rdata_sel = c_half.
- States: IDLE, MUL, DONE.
- IDLE:
  - ready = 1.
  - A START write transfer loads count = 0 and moves to MUL.
  - A START read is illegal.
- MUL:
  - sys_en = 1 and count increments every cycle.
  - At count == 3*DIM-3, go to DONE.
  - ready = 1 only for a STATUS read; every other request is stalled (ready = 0, no strobes).
- DONE:
  - One cycle, sys_en = 0.
  - Sets sticky done.
  - ready behaves as in MUL.
  - Returns to IDLE.
- busy = (state != IDLE).
- Sticky flags:
  - done: cleared by an accepted STATUS read. A set and a clear in the same cycle results in set.
  - err: set by an illegal-address transfer, which completes with no strobe. Cleared by a STATUS read.
- Counter width: clog2(3*DIM-2). It never wraps; it is reloaded on START.

## Timing
- Reset values:
  - All outputs 0, except ready = 1 (IDLE).
  - State IDLE, count 0, done = err = 0.
- Reset asserted mid-MUL aborts the run immediately (asynchronous); sys_en drops without waiting for a clock.
- Write strobe latency: 0 cycles from transfer.
- sys_en is high for exactly 3*DIM-2 consecutive cycles, the first being the cycle after the START transfer.
- DONE occupies the cycle after the last sys_en. The next START can be accepted in the cycle after DONE.
- A back-to-back START in the first IDLE cycle is legal.

## Configuration
- TPU_CTRL_IRQ_EN defined: irq pulses high for exactly the DONE cycle.
- TPU_CTRL_IRQ_EN undefined: irq is tied 0; polling via status is unchanged.

## Structure
- Package tpu_ctrl_pkg holds:
  - state_t {IDLE, MUL, DONE}
  - rdata_sel_t
  - Address base/limit constants: A_BASE, A_LAST, B_BASE, B_LAST, C_BASE, C_LAST, START_ADDR, STATUS_ADDR
- Sub-module tpu_ctrl_decode: purely combinational address-range decode plus row/half extraction. Its outputs are hit_a, hit_b, hit_c, hit_start, hit_status, illegal, a_row, c_row, c_half.
- The FSM, counter and sticky flags live in tpu_ctrl.

## Test plan
Test plan at DIM=8:
- Reset: after reset, ready = 1, status = 0, sys_en = 0, irq = 0.
- A write: write 0x0118 -> a_wr = 1 for one cycle, a_row = 3. Write 0x0378 -> c_wr = 1, c_row = 7, c_half = 1.
- Multiply count: START write at cycle T -> sys_en high cycles T+1..T+22 (22 cycles), DONE at T+23, ready for all requests at T+24. irq high only at T+23 when TPU_CTRL_IRQ_EN is defined.
- Stall during multiply: C read of 0x0300 issued at T+5 -> ready = 0 until T+24, no strobes. STATUS read at T+5 -> accepted, status = 3'b001, rdata_sel = 2.
- Done flag: STATUS read after completion -> status = 3'b010 and done clears. A second read returns 0.
- Errors and reset: illegal write to 0x0500 -> no strobe, err = 1. rst_n low at T+10 mid-run -> sys_en = 0 before the next clk edge, status = 0.
